regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 131 +++++++++++++
 tb/tb_regfile_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised register file with hi/lo pair, hardwired-zero entry 0 and a
// clear sweep FSM. Define REGFILE_BYPASS_EN for write-first (same-cycle) reads.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic                    whl,
  input  logic [ADDR_W-1:0]       wa,
  input  logic [DATA_W-1:0]       wd,
  input  logic [DATA_W-1:0]       wd_hi,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rd,
  output logic [DATA_W-1:0]       hi,
  output logic [DATA_W-1:0]       lo,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    dbg_state_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rf_q [DEPTH];
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic                arr_we;
  logic [ADDR_W-1:0]   arr_wa;
  logic [DATA_W-1:0]   arr_wd;

  // clr_req is a level sampled at the rising edge while IDLE; busy acts as
  // not-ready for array writes, which are dropped (never queued) while high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= CNT_ONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = CNT_ONE;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == '1) begin
          state_d = IDLE;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = CNT_ONE;
      end
    endcase
  end

  always_comb begin
    busy        = (state_q == CLEAR);
    dbg_state_o = state_q;
    arr_we      = 1'b0;
    arr_wa      = cnt_q;
    arr_wd      = '0;
    if (state_q == CLEAR) begin
      arr_we = 1'b1;
    end else if (we && !whl && (wa != '0)) begin
      arr_we = 1'b1;
      arr_wa = wa;
      arr_wd = wd;
    end
  end

  // Storage carries no reset; the post-reset sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      rf_q[arr_wa] <= arr_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we && whl) begin
      hi_q <= wd_hi;
      lo_q <= wd;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hi = (we && whl) ? wd_hi : hi_q;
  assign lo = (we && whl) ? wd    : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic [DATA_W-1:0] rd_k;
    assign ra_k = ra[k*ADDR_W +: ADDR_W];
    always_comb begin
      rd_k = rf_q[ra_k];
      if (busy || (ra_k == '0)) begin
        rd_k = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (we && !whl && (wa == ra_k)) begin
        rd_k = wd;
`endif
      end
    end
    assign rd[k*DATA_W +: DATA_W] = rd_k;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vector table, clear/reset
// sequences and randomized traffic against an array-based reference model.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        we, whl, clr_req;
  logic [4:0]  wa;
  logic [31:0] wd, wd_hi;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [31:0] hi, lo;
  logic        busy, dbg_state;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [31:0] m_rf [32];
  logic [31:0] m_hi, m_lo;
  int          m_busy_left;

  logic [31:0] last_rd0, last_rd1, last_hi, last_lo;
  logic        last_busy;

  typedef struct {
    logic        we, whl;
    logic [4:0]  wa;
    logic [31:0] wd, wd_hi;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1, e_hi, e_lo;
  } vec_t;
  vec_t vecs [9];

  regfile_param dut (
    .clk(clk), .rst_n(rst_n), .we(we), .whl(whl), .wa(wa), .wd(wd),
    .wd_hi(wd_hi), .ra(ra), .rd(rd), .hi(hi), .lo(lo),
    .clr_req(clr_req), .busy(busy), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we_v, whl_v, input logic [4:0] wa_v,
                              input logic [31:0] wd_v, wdh_v, input logic [4:0] r0, r1,
                              input logic [31:0] e0, e1, eh, el);
    vec_t v;
    v.we = we_v; v.whl = whl_v; v.wa = wa_v; v.wd = wd_v; v.wd_hi = wdh_v;
    v.ra0 = r0; v.ra1 = r1; v.e_rd0 = e0; v.e_rd1 = e1; v.e_hi = eh; v.e_lo = el;
    return v;
  endfunction

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    m_hi = '0;
    m_lo = '0;
    m_busy_left = 31;
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (m_busy_left > 0 || a == 0) return '0;
    if (BYP && we && !whl && wa == a) return wd;
    return m_rf[a];
  endfunction

  task automatic model_check();
    chk("rd0", rd[31:0], model_rd(ra[4:0]));
    chk("rd1", rd[63:32], model_rd(ra[9:5]));
    chk("busy", {31'd0, busy}, {31'd0, m_busy_left > 0});
    chk("dbg_state", {31'd0, dbg_state}, {31'd0, m_busy_left > 0});
    chk("hi", hi, (BYP && we && whl) ? wd_hi : m_hi);
    chk("lo", lo, (BYP && we && whl) ? wd : m_lo);
  endtask

  task automatic model_update();
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else begin
      if (we && !whl && wa != 0) m_rf[wa] = wd;
      if (clr_req) begin
        foreach (m_rf[i]) m_rf[i] = '0;
        m_busy_left = 31;
      end
    end
    if (we && whl) begin
      m_hi = wd_hi;
      m_lo = wd;
    end
  endtask

  // driver: one clock cycle of stimulus, sampled mid-cycle, model stepped at the edge
  task automatic cycle(input logic we_v, whl_v, input logic [4:0] wa_v,
                       input logic [31:0] wd_v, wdh_v, input logic [4:0] r0, r1,
                       input logic clr_v, input bit chk_m);
    @(negedge clk);
    we = we_v; whl = whl_v; wa = wa_v; wd = wd_v; wd_hi = wdh_v;
    ra = {r1, r0}; clr_req = clr_v;
    #1;
    last_rd0 = rd[31:0]; last_rd1 = rd[63:32];
    last_hi = hi; last_lo = lo; last_busy = busy;
    if (chk_m) model_check();
    @(posedge clk);
    if (rst_n) model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; we = 1'b0; whl = 1'b0; clr_req = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 1'b1);
      if (last_busy) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    logic [4:0] wa_r;
    rst_n = 1'b0; we = 1'b0; whl = 1'b0; clr_req = 1'b0;
    wa = '0; wd = '0; wd_hi = '0; ra = '0;
    model_reset();

    vecs[0] = mk(1, 0, 5, 32'hDEADBEEF, 0, 5, 5, BYP ? 32'hDEADBEEF : 0, BYP ? 32'hDEADBEEF : 0, 0, 0);
    vecs[1] = mk(0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[2] = mk(1, 0, 0, 32'h1234, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0);
    vecs[3] = mk(0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0);
    vecs[4] = mk(1, 1, 3, 32'h11, 32'h22, 3, 5, 0, 32'hDEADBEEF, BYP ? 32'h22 : 0, BYP ? 32'h11 : 0);
    vecs[5] = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 32'h22, 32'h11);
    vecs[6] = mk(1, 0, 7, 32'hA5, 0, 7, 7, BYP ? 32'hA5 : 0, BYP ? 32'hA5 : 0, 32'h22, 32'h11);
    vecs[7] = mk(1, 0, 7, 32'h5A, 0, 7, 3, BYP ? 32'h5A : 32'hA5, 0, 32'h22, 32'h11);
    vecs[8] = mk(0, 0, 0, 0, 0, 7, 5, 32'h5A, 32'hDEADBEEF, 32'h22, 32'h11);

    // reset pulse and initial sweep
    do_reset();
    count_busy(n);
    chk("reset_sweep_len", n, 32'd31);
    for (int a = 1; a < 32; a++) begin
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'(a), 5'(32 - a), 1'b0, 1'b1);
      chk("post_reset_zero", last_rd0, 32'd0);
    end

    // directed vectors
    foreach (vecs[i]) begin
      cycle(vecs[i].we, vecs[i].whl, vecs[i].wa, vecs[i].wd, vecs[i].wd_hi,
            vecs[i].ra0, vecs[i].ra1, 1'b0, 1'b0);
      chk($sformatf("vec%0d_rd0", i), last_rd0, vecs[i].e_rd0);
      chk($sformatf("vec%0d_rd1", i), last_rd1, vecs[i].e_rd1);
      chk($sformatf("vec%0d_hi", i), last_hi, vecs[i].e_hi);
      chk($sformatf("vec%0d_lo", i), last_lo, vecs[i].e_lo);
    end

    // fill, then clear sweep with writes attempted while busy
    for (int a = 1; a < 32; a++)
      cycle(1'b1, 1'b0, 5'(a), $urandom, 32'd0, 5'(a), 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd20, 1'b0, 1'b1);
    chk("filled_entry", last_rd0, m_rf[9]);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd20, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      wa_r = 5'($urandom_range(1, 31));
      cycle(m_busy_left > 0, 1'b0, wa_r, $urandom, 32'd0, wa_r, 5'd0,
            1'($urandom_range(0, 1)), 1'b1);
      if (last_busy) n++;
      else break;
    end
    chk("clear_sweep_len", n, 32'd31);
    for (int a = 1; a < 32; a++) begin
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'(a), 5'(a), 1'b0, 1'b1);
      chk("post_clear_zero", last_rd1, 32'd0);
    end
    chk("clear_keeps_hi", last_hi, 32'h22);
    chk("clear_keeps_lo", last_lo, 32'h11);

    // reset at sweep cycle 10
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    do_reset();
    count_busy(n);
    chk("restart_sweep_len", n, 32'd31);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 5'($urandom),
            $urandom, $urandom, 5'($urandom), 5'($urandom),
            ($urandom_range(0, 59) == 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
